// File: rtl/branch_control_if.sv
// rtl/branch_control_if.sv - operand/control and decision/statistics bundle for branch_control
interface branch_control_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  opr_a_i;
    logic [XLEN-1:0]  opr_b_i;
    logic             is_b_type_i;
    logic [2:0]       instr_funct3_i;
    logic             branch_taken_o;
    logic             illegal_funct3_o;
    logic             branch_taken_q_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] taken_cnt_o;

    modport master (
        output opr_a_i, opr_b_i, is_b_type_i, instr_funct3_i,
        input  branch_taken_o, illegal_funct3_o, branch_taken_q_o, branch_cnt_o, taken_cnt_o
    );

    modport slave (
        input  opr_a_i, opr_b_i, is_b_type_i, instr_funct3_i,
        output branch_taken_o, illegal_funct3_o, branch_taken_q_o, branch_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/branch_control.sv
// rtl/branch_control.sv - RISC-V branch condition evaluator with registered decision and saturating statistics
module branch_control #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_control_if.slave  bc
);
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [XLEN-1:0]  opr_a;
    logic [XLEN-1:0]  opr_b;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             taken;
    logic             illegal;
    logic             taken_q;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    assign opr_a = bc.opr_a_i;
    assign opr_b = bc.opr_b_i;
    assign eq    = (opr_a == opr_b);
    assign lt_s  = ($signed(opr_a) < $signed(opr_b));
    assign lt_u  = (opr_a < opr_b);

    // Reserved funct3 codes (010/011) fall to the default arm: never taken, flagged illegal.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (bc.is_b_type_i) begin
            case (bc.instr_funct3_i)
                F3_BEQ:  taken = eq;
                F3_BNE:  taken = !eq;
                F3_BLT:  taken = lt_s;
                F3_BGE:  taken = !lt_s;
                F3_BLTU: taken = lt_u;
                F3_BGEU: taken = !lt_u;
                default: illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q    <= 1'b0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            taken_q <= taken;
            if (bc.is_b_type_i && (branch_cnt != {CNT_W{1'b1}}))
                branch_cnt <= branch_cnt + 1'b1;
            if (taken && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

    assign bc.branch_taken_o   = taken;
    assign bc.illegal_funct3_o = illegal;
    assign bc.branch_taken_q_o = taken_q;
    assign bc.branch_cnt_o     = branch_cnt;
    assign bc.taken_cnt_o      = taken_cnt;
endmodule

// File: tb/tb_branch_control.sv
// tb/tb_branch_control.sv - directed self-checking bench for branch_control
module tb_branch_control;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    branch_control_if #(.XLEN(64), .CNT_W(32)) bif ();
    branch_control_if #(.XLEN(64), .CNT_W(4))  bif4 ();

    branch_control #(.XLEN(64), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bc  (bif.slave)
    );

    branch_control #(.XLEN(64), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bc  (bif4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic bt, input logic [2:0] f3);
        bif.opr_a_i        = a;
        bif.opr_b_i        = b;
        bif.is_b_type_i    = bt;
        bif.instr_funct3_i = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(64'h0, 64'h0, 1'b1, 3'b000);
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (bif.branch_taken_q_o !== 1'b0) $display("FAIL reset_q got=%b exp=0", bif.branch_taken_q_o); else pass_cnt++;
        total_cnt++; if (bif.branch_cnt_o !== 32'd0) $display("FAIL reset_branch_cnt got=%0d exp=0", bif.branch_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.taken_cnt_o !== 32'd0) $display("FAIL reset_taken_cnt got=%0d exp=0", bif.taken_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL reset_comb_taken got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_eq_ne();
        drive(64'h1234, 64'h1234, 1'b1, 3'b000); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL beq_equal got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'h1234, 64'h1234, 1'b0, 3'b000); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL beq_not_btype got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'h1234, 64'h5678, 1'b1, 3'b001); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL bne_diff got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'h1234, 64'h5678, 1'b1, 3'b000); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL beq_diff got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'h8000_0000_0000_1234, 64'h1234, 1'b1, 3'b001); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL bne_msb got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'h1234, 64'h5678, 1'b0, 3'b001); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL bne_not_btype got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
    endtask

    task automatic test_signed();
        drive(64'hFFFF_FFFF_FFFF_FE00, 64'h100, 1'b1, 3'b100); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL blt_neg_pos got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'hFFFF_FFFF_FFFF_FE00, 64'h100, 1'b1, 3'b101); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL bge_neg_pos got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'h10, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 3'b100); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL blt_pos_neg got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'hFFFF_FFFF_FFFF_FFA0, 64'hFFFF_FFFF_FFFF_FF10, 1'b1, 3'b100); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL blt_neg_neg got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'h0, 64'h0, 1'b1, 3'b101); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL bge_zero got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'h0, 64'h0, 1'b1, 3'b100); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL blt_zero got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
    endtask

    task automatic test_unsigned();
        drive(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b110); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL bltu_small_big got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b111); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL bgeu_small_big got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'hF000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b1, 3'b111); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL bgeu_msb got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        drive(64'hF000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b1, 3'b110); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL bltu_msb got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'hF000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b1, 3'b100); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL blt_vs_bltu got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
    endtask

    task automatic test_illegal();
        drive(64'h55, 64'h55, 1'b1, 3'b010); #1;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL f3_010_taken got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        total_cnt++; if (bif.illegal_funct3_o !== 1'b1) $display("FAIL f3_010_illegal got=%b exp=1", bif.illegal_funct3_o); else pass_cnt++;
        drive(64'h55, 64'h55, 1'b0, 3'b010); #1;
        total_cnt++; if (bif.illegal_funct3_o !== 1'b0) $display("FAIL f3_010_not_btype got=%b exp=0", bif.illegal_funct3_o); else pass_cnt++;
        drive(64'h1, 64'h2, 1'b1, 3'b011); #1;
        total_cnt++; if (bif.illegal_funct3_o !== 1'b1) $display("FAIL f3_011_illegal got=%b exp=1", bif.illegal_funct3_o); else pass_cnt++;
        total_cnt++; if (bif.branch_taken_o !== 1'b0) $display("FAIL f3_011_taken got=%b exp=0", bif.branch_taken_o); else pass_cnt++;
        drive(64'h55, 64'h55, 1'b1, 3'b000); #1;
        total_cnt++; if (bif.illegal_funct3_o !== 1'b0) $display("FAIL beq_illegal got=%b exp=0", bif.illegal_funct3_o); else pass_cnt++;
    endtask

    task automatic test_counters();
        logic [63:0] va [5];
        logic [63:0] vb [5];
        logic [2:0]  vf [5];
        logic        vt [5];
        va[0] = 64'h7;  vb[0] = 64'h7; vf[0] = 3'b000; vt[0] = 1'b1;
        va[1] = 64'h7;  vb[1] = 64'h7; vf[1] = 3'b001; vt[1] = 1'b0;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'h1; vf[2] = 3'b100; vt[2] = 1'b1;
        va[3] = 64'h3;  vb[3] = 64'h3; vf[3] = 3'b010; vt[3] = 1'b0;
        va[4] = 64'h5;  vb[4] = 64'h3; vf[4] = 3'b111; vt[4] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        drive(64'h0, 64'h0, 1'b0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total_cnt++; if (bif.branch_taken_q_o !== vt[i-1]) $display("FAIL q_follow[%0d] got=%b exp=%b", i - 1, bif.branch_taken_q_o, vt[i-1]); else pass_cnt++;
            end
            drive(va[i], vb[i], 1'b1, vf[i]);
        end
        @(negedge clk);
        total_cnt++; if (bif.branch_taken_q_o !== vt[4]) $display("FAIL q_follow[4] got=%b exp=%b", bif.branch_taken_q_o, vt[4]); else pass_cnt++;
        drive(64'h0, 64'h0, 1'b0, 3'b000);
        total_cnt++; if (bif.branch_cnt_o !== 32'd5) $display("FAIL branch_cnt got=%0d exp=5", bif.branch_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.taken_cnt_o !== 32'd3) $display("FAIL taken_cnt got=%0d exp=3", bif.taken_cnt_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(64'h9, 64'h9, 1'b1, 3'b000);
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (bif.branch_cnt_o !== 32'd7) $display("FAIL pre_reset_cnt got=%0d exp=7", bif.branch_cnt_o); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bif.branch_taken_q_o !== 1'b0) $display("FAIL mid_reset_q got=%b exp=0", bif.branch_taken_q_o); else pass_cnt++;
        total_cnt++; if (bif.branch_cnt_o !== 32'd0) $display("FAIL mid_reset_branch_cnt got=%0d exp=0", bif.branch_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.taken_cnt_o !== 32'd0) $display("FAIL mid_reset_taken_cnt got=%0d exp=0", bif.taken_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.branch_taken_o !== 1'b1) $display("FAIL mid_reset_comb got=%b exp=1", bif.branch_taken_o); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (bif.branch_cnt_o !== 32'd1) $display("FAIL resume_branch_cnt got=%0d exp=1", bif.branch_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.taken_cnt_o !== 32'd1) $display("FAIL resume_taken_cnt got=%0d exp=1", bif.taken_cnt_o); else pass_cnt++;
        total_cnt++; if (bif.branch_taken_q_o !== 1'b1) $display("FAIL resume_q got=%b exp=1", bif.branch_taken_q_o); else pass_cnt++;
        drive(64'h0, 64'h0, 1'b0, 3'b000);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif4.opr_a_i        = 64'hABCD;
        bif4.opr_b_i        = 64'hABCD;
        bif4.is_b_type_i    = 1'b1;
        bif4.instr_funct3_i = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 14) begin
                total_cnt++; if (bif4.branch_cnt_o !== 4'd14) $display("FAIL sat_branch_cnt_14 got=%0d exp=14", bif4.branch_cnt_o); else pass_cnt++;
            end
            if (i == 15) begin
                total_cnt++; if (bif4.taken_cnt_o !== 4'hF) $display("FAIL sat_taken_cnt_15 got=%0d exp=15", bif4.taken_cnt_o); else pass_cnt++;
            end
        end
        bif4.is_b_type_i = 1'b0;
        total_cnt++; if (bif4.branch_cnt_o !== 4'hF) $display("FAIL sat_branch_cnt got=%0d exp=15", bif4.branch_cnt_o); else pass_cnt++;
        total_cnt++; if (bif4.taken_cnt_o !== 4'hF) $display("FAIL sat_taken_cnt got=%0d exp=15", bif4.taken_cnt_o); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        drive(64'h0, 64'h0, 1'b0, 3'b000);
        bif4.opr_a_i        = 64'h0;
        bif4.opr_b_i        = 64'h0;
        bif4.is_b_type_i    = 1'b0;
        bif4.instr_funct3_i = 3'b000;
        test_reset();
        test_eq_ne();
        test_signed();
        test_unsigned();
        test_illegal();
        test_counters();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/branch_control.md
BRANCH_CONTROL -- requirements
Module: branch_control

Interface
Parameters:
REQ-001 The block SHALL provide parameter XLEN, default 64, which sets the operand width.
REQ-002 The block SHALL provide parameter CNT_W, default 32, which sets the statistics counter width.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it SHALL be synchronous and active-high.
REQ-005 The block SHALL have port opr_a_i, input, XLEN, first comparison operand (rs1 value).
REQ-006 The block SHALL have port opr_b_i, input, XLEN, second comparison operand (rs2 value).
REQ-007 The block SHALL have port is_b_type_i, input, 1, which is high when the current instruction is a B-type branch.
REQ-008 The block SHALL have port instr_funct3_i, input, 3, the branch funct3 field.
REQ-009 The block SHALL have port branch_taken_o, output, 1, the combinational branch decision.
REQ-010 The block SHALL have port illegal_funct3_o, output, 1, which flags a B-type instruction with reserved funct3 010 or 011.
REQ-011 The block SHALL have port branch_taken_q_o, output, 1, which is branch_taken_o registered by one cycle.
REQ-012 The block SHALL have port branch_cnt_o, output, CNT_W, the number of B-type instructions evaluated.
REQ-013 The block SHALL have port taken_cnt_o, output, CNT_W, the number of taken branches.

Function
REQ-014 branch_taken_o SHALL be purely combinational from the operand and control inputs, with zero-cycle latency and no dependence on clk or rst.
REQ-015 When is_b_type_i=0, branch_taken_o SHALL be 0 for any operands and any funct3.
REQ-016 With is_b_type_i=1, funct3 000 (BEQ) SHALL give taken = (a == b).
REQ-017 With is_b_type_i=1, funct3 001 (BNE) SHALL give taken = (a != b).
REQ-018 With is_b_type_i=1, funct3 100 (BLT) SHALL give taken = (a < b), comparing both operands as two's-complement signed XLEN values.
REQ-019 With is_b_type_i=1, funct3 101 (BGE) SHALL give taken = (a >= b), signed.
REQ-020 With is_b_type_i=1, funct3 110 (BLTU) SHALL give taken = (a < b), unsigned.
REQ-021 With is_b_type_i=1, funct3 111 (BGEU) SHALL give taken = (a >= b), unsigned.
REQ-022 With is_b_type_i=1 and funct3 010 or 011, branch_taken_o SHALL be 0 and illegal_funct3_o SHALL be 1; illegal_funct3_o SHALL be 0 in all other cases.
REQ-023 Signed comparison SHALL be correct across sign boundaries (negative < positive) and for equal operands, including both operands zero; all XLEN bits SHALL participate.
REQ-024 BGE SHALL equal NOT BLT, and BGEU SHALL equal NOT BLTU, whenever is_b_type_i=1.
REQ-025 branch_taken_q_o SHALL take the value of branch_taken_o at each rising clk edge.
REQ-026 branch_cnt_o SHALL increment by 1 on each rising edge where is_b_type_i=1, including illegal funct3.
REQ-027 taken_cnt_o SHALL increment by 1 on each rising edge where branch_taken_o=1.
REQ-028 Both counters SHALL saturate at all-ones and not wrap.
REQ-029 When both counters would increment on the same edge, each SHALL update independently.

Reset
REQ-030 While rst=1 at a rising edge, branch_taken_q_o, branch_cnt_o and taken_cnt_o SHALL all be set to 0, overriding any increment on that edge.
REQ-031 Reset SHALL NOT affect the combinational outputs branch_taken_o and illegal_funct3_o.
REQ-032 After rst falls, counting SHALL resume on the next qualifying edge.

Verification
REQ-033 BEQ, a=b=0x1234, is_b_type_i=1 -> branch_taken_o=1; the same inputs with is_b_type_i=0 -> 0; BNE with a=0x1234, b=0x5678 -> 1.
REQ-034 BLT signed: a=0xFFFF_FFFF_FFFF_FE00, b=0x100 -> 1; a=0x10, b=0xFFFF_FFFF_FFFF_FF80 -> 0; a=0xFFFF_FFFF_FFFF_FFA0, b=0xFFFF_FFFF_FFFF_FF10 -> 0 (a greater); BGE with a=b=0 -> 1.
REQ-035 BLTU: a=0x1, b=0xFFFF_FFFF_FFFF_FFFF -> 1; BGEU with the same operands -> 0; BGEU a=0xF000_0000_0000_0000, b=0x1000_0000_0000_0000 -> 1.
REQ-036 funct3=010 with is_b_type_i=1 and a=b -> branch_taken_o=0 and illegal_funct3_o=1; the same case with is_b_type_i=0 -> illegal_funct3_o=0.
REQ-037 Reset, then 5 B-type cycles of which 3 are taken -> branch_cnt_o=5, taken_cnt_o=3, and branch_taken_q_o follows branch_taken_o one cycle late; assert rst mid-sequence -> all registered outputs 0 on the next edge.
REQ-038 Preload behaviour at saturation: drive CNT_W=4 with 20 taken branches -> both counters hold 0xF.
